// File: rtl/wptr_full.sv
// wptr_full -- write-side pointer and full-flag logic of an asynchronous FIFO.
//
// Keeps the binary write pointer in the w_clk domain, publishes it as a
// registered Gray pointer for the read domain, brings the read Gray pointer
// across through a two-flop synchroniser and derives a conservative full flag
// together with a sticky overflow flag.
//
// Optional feature: define WPTR_ALMOST_FULL_EN to add the almost_full port and
// its occupancy logic. Without the macro the block has no almost_full port,
// no occupancy counter and no Gray-to-binary converter.

module wptr_full #(
    parameter int FIFO_DEPTH     = 16,
    parameter int FIFO_DEPTH_BIT = 4,
    parameter int ALMOST_FULL_TH = 2
) (
    input  logic                      w_clk,
    input  logic                      w_rst,
    input  logic                      w_req,
    input  logic [FIFO_DEPTH_BIT:0]   r_ptr_gray,
    output logic                      w_en,
    output logic [FIFO_DEPTH_BIT-1:0] write_addr,
    output logic [FIFO_DEPTH_BIT:0]   w_ptr_gray,
    output logic                      flag_full,
`ifdef WPTR_ALMOST_FULL_EN
    output logic                      almost_full,
`endif
    output logic                      overflow
);

    localparam int AW = FIFO_DEPTH_BIT;

    // Reject parameter sets where the address width does not match the depth
    // or the almost-full threshold exceeds the FIFO size.
    if ((FIFO_DEPTH != (1 << FIFO_DEPTH_BIT)) || (ALMOST_FULL_TH > FIFO_DEPTH)
        || (FIFO_DEPTH_BIT < 2)) begin : g_bad_cfg
        $error("wptr_full: inconsistent FIFO_DEPTH / FIFO_DEPTH_BIT / ALMOST_FULL_TH");
    end

    // Binary to reflected Gray code.
    function automatic logic [AW:0] bin2gray(input logic [AW:0] bin);
        return bin ^ (bin >> 1);
    endfunction

`ifdef WPTR_ALMOST_FULL_EN
    // Reflected Gray code back to binary (prefix XOR from the MSB down).
    function automatic logic [AW:0] gray2bin(input logic [AW:0] gray);
        logic [AW:0] bin;
        bin[AW] = gray[AW];
        for (int i = AW - 1; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

    localparam logic [AW:0] AF_LEVEL = (AW+1)'(FIFO_DEPTH - ALMOST_FULL_TH);
`endif

    logic [AW:0] w_bin_r;
    logic [AW:0] rq1_r;
    logic [AW:0] rq2_r;
    logic [AW:0] w_bin_next_s;
    logic [AW:0] w_gray_next_s;
    logic [AW:0] full_target_s;
    logic        full_next_s;

    // Write strobe: only outside reset and only while there is room.
    always_comb begin
        w_en = 1'b0;
        if (!w_rst) begin
            w_en = 1'b0;
        end else begin
            w_en = w_req & ~flag_full;
        end
    end

    // The RAM is written at the current pointer; the pointer advances on the same edge.
    assign write_addr = w_bin_r[AW-1:0];

    // Next pointer, its Gray form and the full comparison against the synchronised read pointer.
    always_comb begin
        w_bin_next_s  = w_bin_r;
        w_gray_next_s = '0;
        full_target_s = '0;
        full_next_s   = 1'b0;
        if (w_en) begin
            w_bin_next_s = w_bin_r + {{AW{1'b0}}, 1'b1};
        end else begin
            w_bin_next_s = w_bin_r;
        end
        w_gray_next_s = bin2gray(w_bin_next_s);
        // Full when the write pointer is exactly one lap ahead: in Gray code the two MSBs differ.
        full_target_s = {~rq2_r[AW:AW-1], rq2_r[AW-2:0]};
        full_next_s   = (w_gray_next_s == full_target_s);
    end

    // Two-flop synchroniser for the read-domain Gray pointer.
    always_ff @(posedge w_clk or negedge w_rst) begin
        if (!w_rst) begin
            rq1_r <= '0;
            rq2_r <= '0;
        end else begin
            rq1_r <= r_ptr_gray;
            rq2_r <= rq1_r;
        end
    end

    // Pointer state, published Gray pointer and full flag.
    always_ff @(posedge w_clk or negedge w_rst) begin
        if (!w_rst) begin
            w_bin_r    <= '0;
            w_ptr_gray <= '0;
            flag_full  <= 1'b0;
        end else begin
            w_bin_r    <= w_bin_next_s;
            w_ptr_gray <= w_gray_next_s;
            flag_full  <= full_next_s;
        end
    end

    // Sticky overflow: any write attempt while full is remembered until reset.
    always_ff @(posedge w_clk or negedge w_rst) begin
        if (!w_rst) begin
            overflow <= 1'b0;
        end else if (w_req && flag_full) begin
            overflow <= 1'b1;
        end else begin
            overflow <= overflow;
        end
    end

`ifdef WPTR_ALMOST_FULL_EN
    logic [AW:0] count_s;

    // Occupancy as seen from the write side (modulo pointer difference).
    always_comb begin
        count_s = '0;
        count_s = w_bin_next_s - gray2bin(rq2_r);
    end

    // Almost-full flag, registered alongside flag_full.
    always_ff @(posedge w_clk or negedge w_rst) begin
        if (!w_rst) begin
            almost_full <= 1'b0;
        end else begin
            almost_full <= (count_s >= AF_LEVEL);
        end
    end
`endif

endmodule

// File: tb/tb_wptr_full.sv
// Directed self-checking bench for wptr_full (default parameters).
// Inputs change at the falling edge; outputs are sampled 1 ns later.

module tb_wptr_full;

    logic       w_clk;
    logic       w_rst;
    logic       w_req;
    logic [4:0] r_ptr_gray;
    logic       w_en;
    logic [3:0] write_addr;
    logic [4:0] w_ptr_gray;
    logic       flag_full;
    logic       overflow;
`ifdef WPTR_ALMOST_FULL_EN
    logic       almost_full;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;

    wptr_full #(
        .FIFO_DEPTH    (16),
        .FIFO_DEPTH_BIT(4),
        .ALMOST_FULL_TH(2)
    ) dut (
        .w_clk      (w_clk),
        .w_rst      (w_rst),
        .w_req      (w_req),
        .r_ptr_gray (r_ptr_gray),
        .w_en       (w_en),
        .write_addr (write_addr),
        .w_ptr_gray (w_ptr_gray),
        .flag_full  (flag_full),
`ifdef WPTR_ALMOST_FULL_EN
        .almost_full(almost_full),
`endif
        .overflow   (overflow)
    );

    initial w_clk = 1'b0;
    always #5 w_clk = ~w_clk;

    // Hold reset for two cycles, release at a falling edge.
    task automatic apply_reset();
        @(negedge w_clk);
        w_req = 1'b0;
        w_rst = 1'b0;
        r_ptr_gray = 5'b00000;
        @(negedge w_clk);
        @(negedge w_clk);
        w_rst = 1'b1;
    endtask

    // Write n words with w_req held high, checking address and strobe each cycle.
    task automatic do_writes(input int n, input int start_addr, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge w_clk);
            w_req = 1'b1;
            #1;
            total_cnt++;
            if (write_addr !== 4'((start_addr + i) % 16) || w_en !== 1'b1)
                $display("FAIL %s[%0d]: addr=%0d w_en=%b, required addr=%0d w_en=1",
                         tag, i, write_addr, w_en, (start_addr + i) % 16);
            else pass_cnt++;
        end
        @(negedge w_clk);
        w_req = 1'b0;
        #1;
    endtask

    // Outputs are zero immediately under reset, before any clock edge, and w_en stays low with w_req=1.
    task automatic test_reset();
        w_rst = 1'b0;
        w_req = 1'b1;
        r_ptr_gray = 5'b00000;
        #3;
        total_cnt++;
        if ({w_en, write_addr, w_ptr_gray, flag_full, overflow} !== 12'h000)
            $display("FAIL reset_initial: en=%b addr=%0d gray=%b full=%b ovf=%b, required all 0",
                     w_en, write_addr, w_ptr_gray, flag_full, overflow);
        else pass_cnt++;
        @(negedge w_clk);
        #1;
        total_cnt++;
        if (w_en !== 1'b0 || write_addr !== 4'd0)
            $display("FAIL reset_wen: w_en=%b addr=%0d, required 0/0", w_en, write_addr);
        else pass_cnt++;
        w_req = 1'b0;
        @(negedge w_clk);
        w_rst = 1'b1;
    endtask

    // Sixteen writes from empty: addresses 0..15, then full with gray 11000.
    task automatic test_fill();
        do_writes(16, 0, "fill");
        total_cnt++;
        if (flag_full !== 1'b1 || w_ptr_gray !== 5'b11000 || write_addr !== 4'd0)
            $display("FAIL fill_full: full=%b gray=%b addr=%0d, required 1/11000/0",
                     flag_full, w_ptr_gray, write_addr);
        else pass_cnt++;
        total_cnt++;
        if (overflow !== 1'b0)
            $display("FAIL fill_no_ovf: overflow=%b, required 0", overflow);
        else pass_cnt++;
    endtask

    // Request while full: no write, no pointer move, sticky overflow.
    task automatic test_overflow();
        @(negedge w_clk);
        w_req = 1'b1;
        #1;
        total_cnt++;
        if (w_en !== 1'b0 || write_addr !== 4'd0)
            $display("FAIL ovf_blocked: w_en=%b addr=%0d, required 0/0", w_en, write_addr);
        else pass_cnt++;
        @(negedge w_clk);
        w_req = 1'b0;
        #1;
        total_cnt++;
        if (overflow !== 1'b1 || w_ptr_gray !== 5'b11000 || write_addr !== 4'd0)
            $display("FAIL ovf_set: ovf=%b gray=%b addr=%0d, required 1/11000/0",
                     overflow, w_ptr_gray, write_addr);
        else pass_cnt++;
        repeat (3) @(negedge w_clk);
        #1;
        total_cnt++;
        if (overflow !== 1'b1 || flag_full !== 1'b1)
            $display("FAIL ovf_sticky: ovf=%b full=%b, required 1/1", overflow, flag_full);
        else pass_cnt++;
    endtask

    // One word read: full must clear within 3 edges; next write goes to address 0 and refills.
    task automatic test_release();
        int edges;
        edges = 0;
        @(negedge w_clk);
        r_ptr_gray = 5'b00001;
        while (flag_full === 1'b1 && edges < 3) begin
            @(negedge w_clk);
            edges++;
            #1;
        end
        total_cnt++;
        if (flag_full !== 1'b0)
            $display("FAIL release_time: full=%b after %0d edges, required 0 within 3", flag_full, edges);
        else pass_cnt++;
        do_writes(1, 0, "release_wr");
        total_cnt++;
        if (w_ptr_gray !== 5'b11001 || flag_full !== 1'b1)
            $display("FAIL release_refull: gray=%b full=%b, required 11001/1", w_ptr_gray, flag_full);
        else pass_cnt++;
    endtask

    // Reset asserted mid-operation clears everything without waiting for a clock.
    task automatic test_reset_midop();
        @(negedge w_clk);
        w_req = 1'b1;
        #2;
        w_rst = 1'b0;
        #1;
        total_cnt++;
        if ({w_en, write_addr, w_ptr_gray, flag_full, overflow} !== 12'h000)
            $display("FAIL reset_midop: en=%b addr=%0d gray=%b full=%b ovf=%b, required all 0",
                     w_en, write_addr, w_ptr_gray, flag_full, overflow);
        else pass_cnt++;
        apply_reset();
    endtask

    // Fill, read all 16, then one more write wraps to address 0 with gray 11001 and not full.
    task automatic test_wrap();
        do_writes(16, 0, "wrap_fill");
        r_ptr_gray = 5'b11000;
        repeat (3) @(negedge w_clk);
        #1;
        total_cnt++;
        if (flag_full !== 1'b0 || write_addr !== 4'd0)
            $display("FAIL wrap_empty: full=%b addr=%0d, required 0/0", flag_full, write_addr);
        else pass_cnt++;
        do_writes(1, 0, "wrap_wr");
        total_cnt++;
        if (w_ptr_gray !== 5'b11001 || flag_full !== 1'b0 || write_addr !== 4'd1)
            $display("FAIL wrap_after: gray=%b full=%b addr=%0d, required 11001/0/1",
                     w_ptr_gray, flag_full, write_addr);
        else pass_cnt++;
    endtask

`ifdef WPTR_ALMOST_FULL_EN
    // Threshold 2: almost_full low after 13 writes, high after 14.
    task automatic test_almost_full();
        apply_reset();
        do_writes(13, 0, "af_13");
        total_cnt++;
        if (almost_full !== 1'b0)
            $display("FAIL af_13: almost_full=%b, required 0", almost_full);
        else pass_cnt++;
        do_writes(1, 13, "af_14");
        total_cnt++;
        if (almost_full !== 1'b1 || flag_full !== 1'b0)
            $display("FAIL af_14: almost_full=%b full=%b, required 1/0", almost_full, flag_full);
        else pass_cnt++;
    endtask
`endif

    initial begin
        w_rst = 1'b0;
        w_req = 1'b0;
        r_ptr_gray = 5'b00000;
        test_reset();
        test_fill();
        test_overflow();
        test_release();
        test_reset_midop();
        test_wrap();
`ifdef WPTR_ALMOST_FULL_EN
        test_almost_full();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
